// File: rtl/pid_pkg.sv
// Purpose: shared types, default widths and the signed-saturation helper for the heading PID.
// Latency: n/a (package only).
// Backpressure: n/a.
package pid_pkg;

    localparam int ERR_W_DEF    = 12;
    localparam int SAT_W_DEF    = 10;
    localparam int SPD_W_DEF    = 11;
    localparam int INT_W_DEF    = 16;
    localparam int P_COEFF_DEF  = 3;
    localparam int D_COEFF_DEF  = 14;
    localparam int I_SHIFT_DEF  = 4;
    localparam int O_SHIFT_DEF  = 3;
    localparam int IN_BAND_DEF  = 30;
    localparam int OUT_BAND_DEF = 40;
    localparam int DWELL_DEF    = 3;

    typedef enum logic [1:0] {
        FAR  = 2'd0,
        NEAR = 2'd1,
        AT   = 2'd2
    } hdng_st_e;

    // Clamp a signed value into the range of a signed field of 'width' bits.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] value, input int width);
        logic signed [31:0] mx;
        logic signed [31:0] mn;
        mx = (32'sd1 <<< (width - 1)) - 32'sd1;
        mn = -(32'sd1 <<< (width - 1));
        if (value > mx)
            return mx;
        else if (value < mn)
            return mn;
        else
            return value;
    endfunction

endpackage

// File: rtl/pid_hdng_dwell.sv
// Purpose: at-heading detector; dwell count to enter AT, wider band to leave it (hysteresis).
// Latency: state and at_hdng update on the edge that samples smp_vld.
// Backpressure: none; evaluates only on smp_vld, clr forces FAR.
// Ports: clk, rst (async high), clr (sync clear), smp_vld, err_sat (signed) -> at_hdng.
module pid_hdng_dwell
    import pid_pkg::*;
#(
    parameter int SAT_W    = SAT_W_DEF,
    parameter int IN_BAND  = IN_BAND_DEF,
    parameter int OUT_BAND = OUT_BAND_DEF,
    parameter int DWELL    = DWELL_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    smp_vld,
    input  logic signed [SAT_W-1:0] err_sat,
    output logic                    at_hdng
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [SAT_W:0]   IN_LIM  = (SAT_W + 1)'(IN_BAND);
    localparam logic [SAT_W:0]   OUT_LIM = (SAT_W + 1)'(OUT_BAND);
    localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);

    hdng_st_e                st, st_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic signed [SAT_W:0]   err_wide;
    logic [SAT_W:0]          err_abs;
    logic                    in_band;
    logic                    out_band;

    always_comb begin
        // One extra bit so |-2^(SAT_W-1)| is representable.
        err_wide = (SAT_W + 1)'(err_sat);
        err_abs  = err_wide[SAT_W] ? -err_wide : err_wide;
        in_band  = err_abs < IN_LIM;
        out_band = err_abs >= OUT_LIM;
        st_nxt   = st;
        cnt_nxt  = cnt;
        if (smp_vld) begin
            case (st)
                FAR: begin
                    if (in_band) begin
                        cnt_nxt = CNT_W'(1);
                        st_nxt  = (DWELL_C == CNT_W'(1)) ? AT : NEAR;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                NEAR: begin
                    if (in_band) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt_nxt == DWELL_C)
                            st_nxt = AT;
                    end else begin
                        st_nxt  = FAR;
                        cnt_nxt = '0;
                    end
                end
                AT: begin
                    // The IN_BAND..OUT_BAND-1 gap keeps AT.
                    if (out_band) begin
                        st_nxt  = FAR;
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    st_nxt  = FAR;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= FAR;
            cnt <= '0;
        end else if (clr) begin
            st  <= FAR;
            cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign at_hdng = (st == AT);

endmodule

// File: rtl/pid_hdng_ctrl.sv
// Purpose: 3-stage pipelined heading PID producing clamped signed left/right wheel speeds.
// Latency: hdng_vld at edge n -> lft_spd/rght_spd/spd_vld after edge n+2; one sample per cycle.
// Backpressure: none; moving=0 flushes the pipeline and zeroes the speeds.
// Ports: clk, rst (async high), moving, hdng_vld, dsrd_hdng, actl_hdng, frwrd_spd
//        -> lft_spd, rght_spd, spd_vld, at_hdng, int_sat.
module pid_hdng_ctrl
    import pid_pkg::*;
#(
    parameter int ERR_W    = ERR_W_DEF,
    parameter int SAT_W    = SAT_W_DEF,
    parameter int SPD_W    = SPD_W_DEF,
    parameter int INT_W    = INT_W_DEF,
    parameter int P_COEFF  = P_COEFF_DEF,
    parameter int D_COEFF  = D_COEFF_DEF,
    parameter int I_SHIFT  = I_SHIFT_DEF,
    parameter int O_SHIFT  = O_SHIFT_DEF,
    parameter int IN_BAND  = IN_BAND_DEF,
    parameter int OUT_BAND = OUT_BAND_DEF,
    parameter int DWELL    = DWELL_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    moving,
    input  logic                    hdng_vld,
    input  logic signed [ERR_W-1:0] dsrd_hdng,
    input  logic signed [ERR_W-1:0] actl_hdng,
    input  logic [SPD_W-1:0]        frwrd_spd,
    output logic signed [SPD_W:0]   lft_spd,
    output logic signed [SPD_W:0]   rght_spd,
    output logic                    spd_vld,
    output logic                    at_hdng,
    output logic                    int_sat
);

    localparam int SUM_W = SAT_W + 5;
    localparam int DIF_W = SAT_W + 1;
    localparam int OUT_W = SPD_W + 1;
    localparam int MIX_W = SPD_W + 2;

    logic signed [ERR_W-1:0] err_q;
    logic                    v1, v2;
    logic signed [SAT_W-1:0] err_sat, hist1, hist2;
    logic signed [DIF_W-1:0] dif;
    logic signed [7:0]       dif_sat;
    logic signed [INT_W-1:0] integ, integ_nxt;
    logic signed [INT_W:0]   int_add;
    logic                    int_ovf;
    logic signed [SUM_W-1:0] p_c, d_c, i_c, p_q, d_q, i_q, sum;
    logic signed [MIX_W-1:0] d_mix, lft_raw, rght_raw;
    logic signed [OUT_W-1:0] lft_c, rght_c;

    always_comb begin
        // Stage 2 terms.
        err_sat   = SAT_W'(sat_s(32'(err_q), SAT_W));
        dif       = DIF_W'(err_sat) - DIF_W'(hist2);
        dif_sat   = 8'(sat_s(32'(dif), 8));
        p_c       = SUM_W'(err_sat) * SUM_W'(P_COEFF);
        d_c       = SUM_W'(dif_sat) * SUM_W'(D_COEFF);
        // Overflow shows up as disagreement between the two top bits of the widened sum.
        int_add   = (INT_W + 1)'(integ) + (INT_W + 1)'(err_sat);
        int_ovf   = int_add[INT_W] != int_add[INT_W-1];
        integ_nxt = int_ovf ? integ : int_add[INT_W-1:0];
        i_c       = SUM_W'(integ_nxt >>> I_SHIFT);
        // Stage 3 mix and clamp.
        sum       = p_q + i_q + d_q;
        d_mix     = MIX_W'(sum >>> O_SHIFT);
        lft_raw   = MIX_W'(signed'({1'b0, frwrd_spd})) + d_mix;
        rght_raw  = MIX_W'(signed'({1'b0, frwrd_spd})) - d_mix;
        lft_c     = OUT_W'(sat_s(32'(lft_raw), OUT_W));
        rght_c    = OUT_W'(sat_s(32'(rght_raw), OUT_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            hist1    <= '0;
            hist2    <= '0;
            integ    <= '0;
            int_sat  <= 1'b0;
            p_q      <= '0;
            d_q      <= '0;
            i_q      <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else if (!moving) begin
            // Flush: in-flight samples are dropped, the next sample starts from clean history.
            v1       <= 1'b0;
            v2       <= 1'b0;
            hist1    <= '0;
            hist2    <= '0;
            integ    <= '0;
            p_q      <= '0;
            d_q      <= '0;
            i_q      <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            v1 <= hdng_vld;
            if (hdng_vld)
                err_q <= actl_hdng - dsrd_hdng;
            v2 <= v1;
            if (v1) begin
                hist2   <= hist1;
                hist1   <= err_sat;
                integ   <= integ_nxt;
                int_sat <= int_ovf;
                p_q     <= p_c;
                d_q     <= d_c;
                i_q     <= i_c;
            end
            spd_vld <= v2;
            if (v2) begin
                lft_spd  <= lft_c;
                rght_spd <= rght_c;
            end
        end
    end

    pid_hdng_dwell #(
        .SAT_W    (SAT_W),
        .IN_BAND  (IN_BAND),
        .OUT_BAND (OUT_BAND),
        .DWELL    (DWELL)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clr      (!moving),
        .smp_vld  (v1),
        .err_sat  (err_sat),
        .at_hdng  (at_hdng)
    );

endmodule
